// File: rtl/matrices_stream_out.sv
// Drain stage for the matrix-sum array: snapshots the flat result bank on i_load and
// replays it one element per cycle on a valid/ready stream with matrix/row/column tags.
module matrices_stream_out #(
  parameter int MATRICES_COUNT = 5,
  parameter int MATRIX_SIZE_M  = 4,
  parameter int MATRIX_SIZE_N  = 3,
  parameter int DATA_WIDTH     = 16,
  localparam int BLOCK_SIZE    = MATRIX_SIZE_M * MATRIX_SIZE_N * DATA_WIDTH,
  localparam int IDX_W         = (MATRICES_COUNT > 1) ? $clog2(MATRICES_COUNT) : 1,
  localparam int ROW_W         = (MATRIX_SIZE_M > 1) ? $clog2(MATRIX_SIZE_M) : 1,
  localparam int COL_W         = (MATRIX_SIZE_N > 1) ? $clog2(MATRIX_SIZE_N) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_load,
  input  logic [BLOCK_SIZE*MATRICES_COUNT-1:0] i_matrices,
  output logic                             o_busy,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [IDX_W-1:0]                 o_matrix_idx,
  output logic [ROW_W-1:0]                 o_row,
  output logic [COL_W-1:0]                 o_col,
  output logic                             o_last_elem,
  output logic                             o_last,
  output logic                             o_done
);

  localparam int BANK_W = BLOCK_SIZE * MATRICES_COUNT;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MATRICES_COUNT - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MATRIX_SIZE_M - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MATRIX_SIZE_N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_reg, state_next;
  logic [BANK_W-1:0]  bank_reg;
  logic [IDX_W-1:0]   mat_reg, mat_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [COL_W-1:0]   col_reg, col_next;
  logic               done_reg, done_next;
  logic               capture;
  logic               streaming;
  logic               last_elem_w;
  logic               last_w;
  logic [31:0]        elem_sel;

  assign streaming   = (state_reg == STREAM);
  assign last_elem_w = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
  assign last_w      = last_elem_w && (mat_reg == IDX_MAX);
  // Flat element index follows the row-major bank layout, matrix-major overall.
  assign elem_sel    = (32'(mat_reg) * MATRIX_SIZE_M + 32'(row_reg)) * MATRIX_SIZE_N + 32'(col_reg);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      bank_reg  <= '0;
      mat_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mat_reg   <= mat_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      done_reg  <= done_next;
      if (capture) begin
        bank_reg <= i_matrices;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mat_next   = mat_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_load) begin
          capture    = 1'b1;
          state_next = STREAM;
          mat_next   = '0;
          row_next   = '0;
          col_next   = '0;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (last_w) begin
            // Counters return to zero so IDLE always presents a clean origin.
            state_next = IDLE;
            done_next  = 1'b1;
            mat_next   = '0;
            row_next   = '0;
            col_next   = '0;
          end else if (col_reg == COL_MAX) begin
            col_next = '0;
            if (row_reg == ROW_MAX) begin
              row_next = '0;
              mat_next = mat_reg + 1'b1;
            end else begin
              row_next = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_valid      = streaming;
  assign o_busy       = streaming;
  assign o_done       = done_reg;
  assign o_matrix_idx = mat_reg;
  assign o_row        = row_reg;
  assign o_col        = col_reg;
  assign o_last_elem  = streaming && last_elem_w;
  assign o_last       = streaming && last_w;
  assign o_data       = streaming ? bank_reg[elem_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_matrices_stream_out.sv
// Directed bench for matrices_stream_out at 5x4x3x16: full drain, backpressure,
// ignored reloads, back-to-back banks and reset both idle and mid-stream.
module tb_matrices_stream_out;

  localparam int MC = 5;
  localparam int M  = 4;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int T  = MC * M * N;
  localparam int BANK_W = MC * M * N * DW;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_load;
  logic [BANK_W-1:0] i_matrices;
  logic              i_ready;
  logic              o_busy, o_valid, o_last_elem, o_last, o_done;
  logic [DW-1:0]     o_data;
  logic [2:0]        o_matrix_idx;
  logic [1:0]        o_row;
  logic [1:0]        o_col;

  int tests_run = 0;
  int tests_failed = 0;

  matrices_stream_out #(
    .MATRICES_COUNT(MC), .MATRIX_SIZE_M(M), .MATRIX_SIZE_N(N), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_matrices(i_matrices),
    .o_busy(o_busy), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_matrix_idx(o_matrix_idx), .o_row(o_row), .o_col(o_col),
    .o_last_elem(o_last_elem), .o_last(o_last), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BANK_W-1:0] make_bank();
    logic [BANK_W-1:0] b;
    b = '0;
    for (int i = 0; i < MC; i++)
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          b[((i*M + r)*N + c)*DW +: DW] = DW'(100*i + 10*r + c);
    return b;
  endfunction

  // {data, idx, row, col, last_elem, last, busy, valid, done}
  function automatic logic [31:0] obs();
    return {4'b0, o_data, o_matrix_idx, o_row, o_col, o_last_elem, o_last, o_busy, o_valid, o_done};
  endfunction

  function automatic logic [31:0] exp_beat(int k);
    int i, r, c;
    logic le, l;
    i  = k / (M*N);
    r  = (k % (M*N)) / N;
    c  = k % N;
    le = (r == M-1) && (c == N-1);
    l  = le && (i == MC-1);
    return {4'b0, DW'(100*i + 10*r + c), 3'(i), 2'(r), 2'(c), le, l, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic load_bank();
    i_matrices = make_bank();
    i_load = 1'b1;
    @(posedge i_clk); #1;
    i_load = 1'b0;
  endtask

  // Runs until 'limit' handshakes; every cycle the outputs are checked against beat n.
  task automatic drain(input int pct, input bit noise, input int limit);
    int n, cyc;
    bit hs;
    n = 0;
    cyc = 0;
    while (n < limit && cyc < 2000) begin
      i_ready = ($urandom_range(0, 99) < pct);
      if (noise && (n == 20 || n == T-1)) begin
        i_matrices = '1;
        i_load = 1'b1;
        if (n == T-1) i_ready = 1'b1;
      end else begin
        i_load = 1'b0;
      end
      chk($sformatf("beat%0d", n), obs(), exp_beat(n));
      hs = o_valid && i_ready;
      if (hs) $display("[TB] beat %0d data %0d m%0d r%0d c%0d", n, o_data, o_matrix_idx, o_row, o_col);
      @(posedge i_clk); #1;
      if (hs) n++;
      cyc++;
    end
    i_load = 1'b0;
    i_ready = 1'b0;
    if (cyc >= 2000) chk("timeout", 32'(n), 32'(limit));
    if (limit == T) chk("done_cycle", {29'b0, o_valid, o_busy, o_done}, 32'b001);
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_load = 1'b0;
    i_ready = 1'b0;
    i_matrices = '0;
    #2 i_rst_n = 1'b0;
    #1 chk("rst_outputs", obs(), 32'h0);
    #20 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("idle_after_rst", obs(), 32'h0);

    // Full drain, ready held high
    load_bank();
    drain(100, 1'b0, T);
    @(posedge i_clk); #1;
    chk("done_one_cycle", obs(), 32'h0);

    // Backpressure at ~30% ready
    load_bank();
    drain(30, 1'b0, T);
    @(posedge i_clk); #1;
    chk("idle_after_bp", obs(), 32'h0);

    // Reload attempts mid-stream and on the final handshake must be ignored
    load_bank();
    drain(100, 1'b1, T);
    i_matrices = make_bank();
    @(posedge i_clk); #1;
    chk("no_restart", obs(), 32'h0);

    // Back-to-back: load on the o_done cycle
    load_bank();
    drain(100, 1'b0, T);
    load_bank();
    drain(100, 1'b0, T);
    @(posedge i_clk); #1;
    chk("idle_after_b2b", obs(), 32'h0);

    // Reset mid-stream after value 112 has been accepted
    load_bank();
    drain(100, 1'b0, 18);
    #2 i_rst_n = 1'b0;
    #1 chk("rst_abort", obs(), 32'h0);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("no_done_after_abort", obs(), 32'h0);
    @(posedge i_clk); #1;
    chk("idle_after_abort", obs(), 32'h0);
    load_bank();
    drain(100, 1'b0, T);
    @(posedge i_clk); #1;
    chk("idle_final", obs(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
